// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial WIDTH-bit adder, BPC bits per clock, start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             count,
  output logic             overflow
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  generate
    if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_params
      $error("serial_adder: illegal WIDTH/BPC combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    step;

  logic [BPC:0]     digit;
  logic [WIDTH-1:0] sum_next;
  logic             msb_cin;

  always_comb begin
    digit    = {1'b0, a_sh[BPC-1:0]} + {1'b0, b_sh[BPC-1:0]} + {{BPC{1'b0}}, carry};
    sum_next = (sum_sh >> BPC) | (WIDTH'(digit[BPC-1:0]) << (WIDTH - BPC));
    // Carry into the digit's top bit recovered from its sum bit; on the last step that top bit is the MSB.
    msb_cin  = a_sh[BPC-1] ^ b_sh[BPC-1] ^ digit[BPC-1];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      step     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      count    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= in_1;
            b_sh   <= in_2;
            carry  <= cin;
            sum_sh <= '0;
            step   <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> BPC;
          b_sh   <= b_sh >> BPC;
          sum_sh <= sum_next;
          carry  <= digit[BPC];
          step   <= step + 1'b1;
          if (step == LAST_STEP) begin
            sum      <= sum_next;
            count    <= digit[BPC];
            overflow <= msb_cin ^ digit[BPC];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random checks of serial_adder across several WIDTH/BPC configurations
module tb_serial_adder;

  localparam int NI = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        st [NI];
  logic [31:0] ia [NI];
  logic [31:0] ib [NI];
  logic        ci [NI];
  wire         bz [NI];
  wire         dn [NI];
  wire         co [NI];
  wire         ov [NI];
  wire  [31:0] sm [NI];

  // Instances: 0:(8,1) 1:(8,2) 2:(16,4) 3:(32,8) 4:(8,4) 5:(8,8)
  function automatic int wid(input int k);
    case (k)
      2:       return 16;
      3:       return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int bpc(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      3:       return 8;
      4:       return 4;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 2) ? 16 : ((g == 3) ? 32 : 8);
    localparam int B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : (g == 4) ? 4 : 8;
    logic         bw, dw, cw, ow;
    logic [W-1:0] sw;
    serial_adder #(.WIDTH(W), .BPC(B)) u_dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .start    (st[g]),
      .in_1     (ia[g][W-1:0]),
      .in_2     (ib[g][W-1:0]),
      .cin      (ci[g]),
      .busy     (bw),
      .done     (dw),
      .sum      (sw),
      .count    (cw),
      .overflow (ow)
    );
    assign bz[g] = bw;
    assign dn[g] = dw;
    assign co[g] = cw;
    assign ov[g] = ow;
    assign sm[g] = 32'(sw);
  end

  // Drives one accepted start and waits for done; lat = edges from acceptance to done.
  task automatic do_add(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                        output int lat, output int busy_err);
    @(negedge clk);
    ia[k] = a; ib[k] = b; ci[k] = c; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    lat = 0;
    busy_err = 0;
    while (lat < 80 && dn[k] !== 1'b1) begin
      if (bz[k] !== 1'b1) busy_err++;
      @(negedge clk);
      lat++;
    end
    if (bz[k] !== 1'b0) busy_err++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      total++;
      if ({bz[k], dn[k], co[k], ov[k], sm[k]} !== 36'd0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got busy=%b done=%b count=%b ovf=%b sum=%h want all 0",
                 k, bz[k], dn[k], co[k], ov[k], sm[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, berr;
    do_add(0, 32'd100, 32'd27, 1'b0, lat, berr);
    total++;
    if (lat !== 8 || berr !== 0) begin
      bad++;
      $display("FAIL basic_latency got lat=%0d busy_err=%0d want lat=8 busy_err=0", lat, berr);
    end
    total++;
    if ({co[0], ov[0], sm[0]} !== {1'b0, 1'b0, 32'd127}) begin
      bad++;
      $display("FAIL basic_result got count=%b ovf=%b sum=%0d want 0 0 127", co[0], ov[0], sm[0]);
    end
    @(negedge clk);
    total++;
    if (dn[0] !== 1'b0 || sm[0] !== 32'd127) begin
      bad++;
      $display("FAIL basic_pulse got done=%b sum=%0d want done=0 sum=127 held", dn[0], sm[0]);
    end
  endtask

  task automatic test_corners;
    logic [31:0] va [3] = '{32'hFF, 32'h7F, 32'hFF};
    logic [31:0] vb [3] = '{32'h01, 32'h01, 32'hFF};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] es [3] = '{32'h00, 32'h80, 32'hFF};
    logic        ec [3] = '{1'b1, 1'b0, 1'b1};
    logic        eo [3] = '{1'b0, 1'b1, 1'b0};
    int lat, berr;
    for (int i = 0; i < 3; i++) begin
      do_add(0, va[i], vb[i], vc[i], lat, berr);
      total++;
      if ({co[0], ov[0], sm[0]} !== {ec[i], eo[i], es[i]} || lat !== 8) begin
        bad++;
        $display("FAIL corner_%0d got count=%b ovf=%b sum=%h lat=%0d want count=%b ovf=%b sum=%h lat=8",
                 i, co[0], ov[0], sm[0], lat, ec[i], eo[i], es[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int cnt;
    @(negedge clk);
    ia[0] = 32'h3C; ib[0] = 32'h55; ci[0] = 1'b1; st[0] = 1'b1;
    @(negedge clk);
    lat = 0;
    while (lat < 80 && dn[0] !== 1'b1) begin
      st[0] = 1'($urandom_range(0, 1));
      ia[0] = $urandom; ib[0] = $urandom; ci[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    total++;
    if ({co[0], ov[0], sm[0]} !== {1'b0, 1'b1, 32'h92} || lat !== 8) begin
      bad++;
      $display("FAIL ignore_start got count=%b ovf=%b sum=%h lat=%0d want 0 1 92 lat=8", co[0], ov[0], sm[0], lat);
    end
    ia[0] = 32'h01; ib[0] = 32'h02; ci[0] = 1'b0; st[0] = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      st[0] = 1'b0;
      cnt++;
    end while (cnt < 80 && dn[0] !== 1'b1);
    total++;
    if (cnt !== 9 || {co[0], ov[0], sm[0]} !== {1'b0, 1'b0, 32'h03}) begin
      bad++;
      $display("FAIL back_to_back got gap=%0d count=%b ovf=%b sum=%h want gap=9 0 0 03", cnt, co[0], ov[0], sm[0]);
    end
  endtask

  task automatic test_async_reset;
    int lat, berr, pulses;
    @(negedge clk);
    ia[0] = 32'h12; ib[0] = 32'h34; ci[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bz[0], dn[0], co[0], ov[0], sm[0]} !== 36'd0) begin
      bad++;
      $display("FAIL async_reset got busy=%b done=%b count=%b ovf=%b sum=%h want all 0",
               bz[0], dn[0], co[0], ov[0], sm[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dn[0] === 1'b1 || bz[0] === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL reset_abort got %0d cycles with busy/done after reset want 0", pulses);
    end
    do_add(0, 32'h12, 32'h34, 1'b0, lat, berr);
    total++;
    if (sm[0] !== 32'h46 || co[0] !== 1'b0 || lat !== 8 || berr !== 0) begin
      bad++;
      $display("FAIL post_reset got sum=%h count=%b lat=%0d busy_err=%0d want 46 0 8 0", sm[0], co[0], lat, berr);
    end
  endtask

  task automatic test_wide_digits;
    int lat, berr;
    for (int k = 4; k < 6; k++) begin
      do_add(k, 32'hA5, 32'h5A, 1'b1, lat, berr);
      total++;
      if ({co[k], ov[k], sm[k]} !== {1'b1, 1'b0, 32'h00} || lat !== 8 / bpc(k) || berr !== 0) begin
        bad++;
        $display("FAIL wide_digit bpc=%0d got count=%b ovf=%b sum=%h lat=%0d busy_err=%0d want 1 0 00 lat=%0d",
                 bpc(k), co[k], ov[k], sm[k], lat, berr, 8 / bpc(k));
      end
    end
  endtask

  task automatic test_regression;
    int lat, berr, w;
    logic [31:0] a, b, mask, exp_sum;
    logic        c, exp_co, exp_ov;
    logic [32:0] full;
    for (int k = 0; k < 4; k++) begin
      w = wid(k);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      for (int i = 0; i < 1000; i++) begin
        a = $urandom & mask;
        b = $urandom & mask;
        c = 1'($urandom_range(0, 1));
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        exp_sum = full[31:0] & mask;
        exp_co = full[w];
        exp_ov = (a[w-1] == b[w-1]) && (exp_sum[w-1] != a[w-1]);
        do_add(k, a, b, c, lat, berr);
        total++;
        if ({co[k], ov[k], sm[k]} !== {exp_co, exp_ov, exp_sum} || lat !== w / bpc(k) || berr !== 0) begin
          bad++;
          $display("FAIL regress w=%0d bpc=%0d a=%h b=%h c=%b got count=%b ovf=%b sum=%h lat=%0d berr=%0d want %b %b %h lat=%0d",
                   w, bpc(k), a, b, c, co[k], ov[k], sm[k], lat, berr, exp_co, exp_ov, exp_sum, w / bpc(k));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      st[k] = 1'b0; ia[k] = '0; ib[k] = '0; ci[k] = 1'b0;
    end
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_async_reset();
    test_wide_digits();
    test_regression();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
